// File: rtl/link_monitor_pkg.sv
// Shared types and helpers for the loopback link monitor.
// Latency: n/a (package of types and pure functions).
// Backpressure: n/a.
package link_monitor_pkg;

  // Widest lane count that the popcount helper handles.
  localparam int MAX_LANES = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Number of set bits. Callers zero-extend narrower words to MAX_LANES.
  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // a + b clamped to the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [64:0] sum;
    logic [64:0] mx;
    sum = {1'b0, a} + {1'b0, b};
    if (w >= 64) mx = {1'b0, {64{1'b1}}};
    else         mx = (65'd1 << w) - 65'd1;
    return (sum > mx) ? mx[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/link_monitor_sync_fifo.sv
// Synchronous first-word-fall-through FIFO holding transmitted words for alignment.
// Latency: a pushed word is visible on rdata the cycle after the push edge.
// Backpressure: none; push when full without pop is dropped, pop when empty is ignored (no bypass).
// Ports: Clock, Reset (sync, active high, empties), push/wdata, pop/rdata, full, empty.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 256
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push && !Reset) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/link_monitor.sv
// Loopback link monitor: forwards channel with optional bit-error injection, aligns TX vs RX payload, counts errors.
// Latency: ChanOut combinational; ErrorCount/BitCount/Mismatch/Latency update one cycle after the RxValid cycle.
// Backpressure: none; FIFO overflow or underflow moves the monitor to FAULT until Start or Reset.
// Ports: Clock, Reset, Start; TxData/TxValid in; ChanIn -> ChanOut; InjectPeriod; RxData/RxValid in;
//        Locked, Fault, Mismatch, ErrorCount, BitCount, Latency out.
module link_monitor
  import link_monitor_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int DEPTH   = 256,
  parameter int COUNT_W = 32,
  parameter int LAT_W   = 16,
  parameter int PER_W   = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [LANES-1:0]   TxData,
  input  logic               TxValid,
  input  logic [LANES-1:0]   ChanIn,
  output logic [LANES-1:0]   ChanOut,
  input  logic [PER_W-1:0]   InjectPeriod,
  input  logic [LANES-1:0]   RxData,
  input  logic               RxValid,
  output logic               Locked,
  output logic               Fault,
  output logic               Mismatch,
  output logic [COUNT_W-1:0] ErrorCount,
  output logic [COUNT_W-1:0] BitCount,
  output logic [LAT_W-1:0]   Latency
);

  state_t           state;
  state_t           state_nxt;
  logic             active;
  logic             push_req;
  logic             pop_req;
  logic             fifo_clr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LANES-1:0] fifo_head;
  logic             overflow;
  logic             underflow;
  logic             compare;
  logic [31:0]      bit_err;
  logic             lat_run;
  logic [LAT_W-1:0] lat_cnt;
  logic [PER_W-1:0] inj_cnt;
  logic             inj_hit;

  assign active   = (state == ST_ARMED) || (state == ST_TRACK);
  // Traffic in the Start cycle belongs to the previous run and is discarded.
  assign push_req = active && !Start && TxValid;
  assign pop_req  = active && !Start && RxValid;
  assign fifo_clr = Reset || Start;

  assign overflow  = push_req && fifo_full && !pop_req;
  assign underflow = pop_req && fifo_empty;
  assign compare   = pop_req && !fifo_empty;
  assign bit_err   = popcount(MAX_LANES'(fifo_head ^ RxData));

  sync_fifo #(
    .WIDTH(LANES),
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (fifo_clr),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (TxData),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. In ARMED, RxValid before any push shows up as an underflow.
  always_comb begin
    state_nxt = state;
    if (Start) begin
      state_nxt = ST_ARMED;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_ARMED: begin
          if (overflow || underflow) state_nxt = ST_FAULT;
          else if (compare)          state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          if (overflow || underflow) state_nxt = ST_FAULT;
        end
        default:  state_nxt = ST_FAULT;
      endcase
    end
  end

  // Outputs decoded from state. Injection is suppressed while Reset is asserted.
  always_comb begin
    Locked  = (state == ST_TRACK);
    Fault   = (state == ST_FAULT);
    inj_hit = !Reset && active && (InjectPeriod != '0) &&
              (inj_cnt == InjectPeriod - PER_W'(1));
    ChanOut = ChanIn ^ LANES'(inj_hit);
  end

  // Statistics, latency and injection counters.
  always_ff @(posedge Clock) begin
    if (Reset || Start) begin
      Mismatch   <= 1'b0;
      ErrorCount <= '0;
      BitCount   <= '0;
      Latency    <= '0;
      lat_run    <= 1'b0;
      lat_cnt    <= '0;
      inj_cnt    <= '0;
    end else begin
      Mismatch <= 1'b0;

      // Comparing with >= lets a shrunken period wrap immediately.
      if (active && InjectPeriod != '0) begin
        if (inj_cnt >= InjectPeriod - PER_W'(1)) inj_cnt <= '0;
        else                                     inj_cnt <= inj_cnt + PER_W'(1);
      end else if (state == ST_IDLE || InjectPeriod == '0) begin
        inj_cnt <= '0;
      end

      // The counter reads 0 in the first push cycle, so it holds 1 one cycle later.
      if (state == ST_ARMED) begin
        if (!lat_run && push_req) begin
          lat_run <= 1'b1;
          lat_cnt <= LAT_W'(1);
        end else if (lat_run && lat_cnt != '1) begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
        if (compare) Latency <= lat_cnt;
      end

      if (compare) begin
        ErrorCount <= COUNT_W'(sat_add(64'(ErrorCount), 64'(bit_err), COUNT_W));
        BitCount   <= COUNT_W'(sat_add(64'(BitCount), 64'(LANES), COUNT_W));
        Mismatch   <= (bit_err != 32'd0);
      end
    end
  end

endmodule

// File: doc/link_monitor.md
Name: link_monitor

Overview:
Parametrised closed-loop link monitor placed between the 802.11a transmitter output and the receiver input inside a loopback test harness.
- Forwards channel data with optional periodic bit-error injection.
- Buffers the transmitted payload and aligns it against received payload.
- Measures transmit-to-receive latency, and counts compared bits and bit errors, with fault detection.
- Generalises a fixed 1-bit loopback to LANES bits per cycle and a configurable alignment depth.

Parameters:
LANES, 1, bits per cycle on every data path
DEPTH, 256, alignment FIFO depth in words; power of two, at least 2
COUNT_W, 32, width of ErrorCount and BitCount
LAT_W, 16, width of Latency
PER_W, 16, width of InjectPeriod

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous active-high reset
Start  input  1  one-shot: clear statistics and arm a new measurement; valid in any state
TxData  input  LANES  payload word entering the transmitter
TxValid  input  1  TxData valid this cycle
ChanIn  input  LANES  transmitter output (antenna)
ChanOut  output  LANES  to receiver input: ChanIn XOR injection mask, combinational
InjectPeriod  input  PER_W  0 = no injection; N = flip ChanOut bit 0 once every N cycles
RxData  input  LANES  receiver output word
RxValid  input  1  RxData valid this cycle
Locked  output  1  high in TRACK
Fault  output  1  high in FAULT
Mismatch  output  1  registered one-cycle pulse per compared word with at least one bit error
ErrorCount  output  COUNT_W  accumulated bit errors, saturating
BitCount  output  COUNT_W  accumulated compared bits, saturating
Latency  output  LAT_W  cycles from first accepted TxValid to first RxValid, saturating

Behaviour:
- Reset, taking priority over everything else:
  - State goes to IDLE and the FIFO is emptied.
  - All outputs are 0, and the injection counter is 0.
  - ChanOut = ChanIn.
- Start, outside reset, from any state on the next edge:
  - State goes to ARMED.
  - FIFO, ErrorCount, BitCount, Latency, latency counter, injection counter and Mismatch are cleared.
  - TxValid/RxValid in the Start cycle are ignored.
- IDLE: TxValid and RxValid are ignored; the injection counter is held at 0.
- ARMED:
  - TxValid pushes TxData.
  - The first accepted push starts the latency counter at 0, incrementing every cycle.
  - First RxValid:
    - Latency is set to the counter value.
    - The FIFO head is popped and compared.
    - State goes to TRACK.
  - RxValid before any push is a FAULT.
- TRACK: each TxValid pushes; each RxValid pops the head and compares against RxData.
- Per compare:
  - e = popcount(head XOR RxData).
  - ErrorCount += e and BitCount += LANES, both saturating at all-ones.
  - Mismatch is 1 on the following cycle if e != 0.
- FIFO boundaries:
  - Push and pop in the same cycle when full is legal, with no overflow.
  - Push when full without pop is an overflow: the word is dropped and state goes to FAULT.
  - Pop when empty (no bypass, even with a simultaneous push) is an underflow: state goes to FAULT.
- FAULT:
  - Counters are frozen and Locked = 0.
  - Exit only via Start or Reset.
- Latency counter saturates at 2^LAT_W-1; it stops once latched.
- Injection, in ARMED/TRACK with InjectPeriod = N > 0:
  - The counter runs 0..N-1 and wraps.
  - ChanOut[0] is inverted in the cycle the counter equals N-1.
  - A change of InjectPeriod mid-run takes effect at the next wrap; if the counter is already ≥ N, it wraps next cycle.
- Latency of statistics: ErrorCount, BitCount and Mismatch update one cycle after the RxValid cycle.

Decomposition:
- Package link_monitor_pkg holds:
  - the state encoding (IDLE, ARMED, TRACK, FAULT);
  - a popcount function;
  - a saturating-add helper.
- Sub-module sync_fifo (parameters WIDTH, DEPTH), with:
  - ports Clock, Reset, push, pop, wdata, rdata, full, empty;
  - first-word-fall-through output;
  - behaviour exactly as the FIFO boundary rules above.

Test Plan:
1. LANES=1, InjectPeriod=0; Start, then 64 TxValid bits echoed on RxValid 7 cycles later → Latency=7, BitCount=64, ErrorCount=0, Locked=1, Mismatch never asserted.
2. InjectPeriod=4, receiver model returns ChanOut bits → ErrorCount=16 after 64 bits, Mismatch pulses every 4th compare, BitCount=64.
3. DEPTH=4, 5 pushes with no RxValid → Fault=1 on the 5th push edge, counters frozen; then Start → Fault=0, ARMED, counters 0.
4. RxValid asserted in ARMED before any TxValid → Fault=1, Latency=0, BitCount=0.
5. LANES=4; TxData=4'hA, RxData=4'h5 → ErrorCount=4, BitCount=4, Mismatch=1 for exactly one cycle.
6. Reset asserted mid-TRACK with the FIFO holding 3 words → next cycle all outputs 0 and state IDLE; a later RxValid is ignored until Start.
